// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a CPU write to FF46 copies a 160-byte source page into OAM,
// one byte per clock, through a fixed-latency source-read pipeline.
module oam_dma_engine #(
    parameter logic [15:0] OAM_START   = 16'hFE00,
    parameter int          OAM_LEN     = 160,
    parameter int          RD_LATENCY  = 1,
    parameter int          START_DELAY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_wr_i,
    input  logic [7:0]  reg_din_i,
    output logic [7:0]  reg_dout_o,
    output logic [15:0] src_a_o,
    output logic        src_rd_o,
    input  logic [7:0]  src_dout_i,
    output logic [15:0] oam_a_o,
    output logic [7:0]  oam_din_o,
    output logic        oam_wr_o,
    output logic        dma_active_o,
    output logic        done_out_o
);

    localparam logic [7:0] LAST_IDX   = 8'(OAM_LEN - 1);
    localparam logic [1:0] START_LAST = 2'(START_DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Pages E0..FF are echoes of C0..DF and are fetched from the real page.
    function automatic logic [7:0] echo_map(input logic [7:0] v);
        logic [7:0] r;
        if (v >= 8'hE0) begin
            r = v - 8'h20;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  reg_dout_q, reg_dout_d;
    logic [7:0]  rd_idx_q, rd_idx_d;
    logic [1:0]  start_cnt_q, start_cnt_d;
    logic        dma_active_q, dma_active_d;
    logic        done_q, done_d;
    logic        src_rd_q, src_rd_d;
    logic [15:0] src_a_q, src_a_d;
    logic        oam_wr_q, oam_wr_d;
    logic [15:0] oam_a_q, oam_a_d;
    logic [7:0]  oam_din_q, oam_din_d;

    // Entry i of the pipeline holds the read issued i cycles ago; the last
    // stage lines up with the cycle in which src_dout_i carries its byte.
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [7:0]            pipe_idx_q [RD_LATENCY];
    logic [7:0]            pipe_idx_d [RD_LATENCY];

    logic       issue_s;
    logic [7:0] issue_page_s;
    logic [7:0] issue_idx_s;
    logic       flush_s;
    logic [7:0] mapped_page_s;
    logic       emerge_vld_s;
    logic [7:0] emerge_idx_s;

    assign mapped_page_s = echo_map(reg_din_i);
    assign emerge_vld_s  = pipe_vld_q[RD_LATENCY-1];
    assign emerge_idx_s  = pipe_idx_q[RD_LATENCY-1];

    // Next-state, read issue, write pipeline and restart handling.
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        reg_dout_d   = reg_dout_q;
        rd_idx_d     = rd_idx_q;
        start_cnt_d  = start_cnt_q;
        dma_active_d = dma_active_q;
        done_d       = 1'b0;
        issue_s      = 1'b0;
        issue_page_s = page_q;
        issue_idx_s  = rd_idx_q;
        flush_s      = 1'b0;
        pipe_vld_d   = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_idx_d[i] = pipe_idx_q[i];
        end

        oam_wr_d = emerge_vld_s;
        if (emerge_vld_s) begin
            oam_a_d   = OAM_START + {8'h00, emerge_idx_s};
            oam_din_d = src_dout_i;
        end else begin
            oam_a_d   = 16'h0000;
            oam_din_d = 8'h00;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_START: begin
                if (start_cnt_q == START_LAST) begin
                    issue_s     = 1'b1;
                    issue_idx_s = 8'h00;
                    rd_idx_d    = 8'h01;
                    state_d     = ST_XFER;
                end else begin
                    start_cnt_d = start_cnt_q + 2'd1;
                end
            end
            ST_XFER: begin
                issue_s = 1'b1;
                if (rd_idx_q == LAST_IDX) begin
                    rd_idx_d = 8'h00;
                    state_d  = ST_DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + 8'h01;
                end
            end
            ST_DRAIN: begin
                if (pipe_vld_q == '0) begin
                    state_d      = ST_IDLE;
                    dma_active_d = 1'b0;
                    done_d       = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                dma_active_d = 1'b0;
            end
        endcase

        // A new FF46 write wins over everything, including a finishing drain.
        if (reg_wr_i) begin
            flush_s      = 1'b1;
            page_d       = mapped_page_s;
            reg_dout_d   = reg_din_i;
            rd_idx_d     = 8'h00;
            start_cnt_d  = 2'd0;
            dma_active_d = 1'b1;
            done_d       = 1'b0;
            oam_wr_d     = 1'b0;
            oam_a_d      = 16'h0000;
            oam_din_d    = 8'h00;
            if (START_DELAY == 0) begin
                issue_s      = 1'b1;
                issue_page_s = mapped_page_s;
                issue_idx_s  = 8'h00;
                rd_idx_d     = 8'h01;
                state_d      = ST_XFER;
            end else begin
                issue_s = 1'b0;
                state_d = ST_START;
            end
        end else begin
            flush_s = 1'b0;
        end

        src_rd_d = issue_s;
        if (issue_s) begin
            src_a_d = {issue_page_s, issue_idx_s};
        end else begin
            src_a_d = 16'h0000;
        end

        for (int i = RD_LATENCY - 1; i > 0; i--) begin
            pipe_vld_d[i] = pipe_vld_q[i-1] & ~flush_s;
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end
        pipe_vld_d[0] = issue_s;
        pipe_idx_d[0] = issue_idx_s;
    end

    // State, pipeline and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            page_q       <= 8'h00;
            reg_dout_q   <= 8'hFF;
            rd_idx_q     <= 8'h00;
            start_cnt_q  <= 2'd0;
            dma_active_q <= 1'b0;
            done_q       <= 1'b0;
            src_rd_q     <= 1'b0;
            src_a_q      <= 16'h0000;
            oam_wr_q     <= 1'b0;
            oam_a_q      <= 16'h0000;
            oam_din_q    <= 8'h00;
            pipe_vld_q   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_idx_q[i] <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            page_q       <= page_d;
            reg_dout_q   <= reg_dout_d;
            rd_idx_q     <= rd_idx_d;
            start_cnt_q  <= start_cnt_d;
            dma_active_q <= dma_active_d;
            done_q       <= done_d;
            src_rd_q     <= src_rd_d;
            src_a_q      <= src_a_d;
            oam_wr_q     <= oam_wr_d;
            oam_a_q      <= oam_a_d;
            oam_din_q    <= oam_din_d;
            pipe_vld_q   <= pipe_vld_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_idx_q[i] <= pipe_idx_d[i];
            end
        end
    end

    assign reg_dout_o   = reg_dout_q;
    assign src_a_o      = src_a_q;
    assign src_rd_o     = src_rd_q;
    assign oam_a_o      = oam_a_q;
    assign oam_din_o    = oam_din_q;
    assign oam_wr_o     = oam_wr_q;
    assign dma_active_o = dma_active_q;
    assign done_out_o   = done_q;

endmodule
